// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding, synchroniser depth and
// channel-width bounds common to the transmitter and receiver.
package i2s_pkg;

  typedef enum logic {
    SYNC,
    RUN
  } i2s_state_t;

  localparam int unsigned SYNC_DEPTH   = 2;
  localparam int unsigned AUDIO_DW_MIN = 8;
  localparam int unsigned AUDIO_DW_MAX = 32;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for one asynchronous I2S pin. With EDGE_DETECT set,
// q is a one-cycle pulse on each synchronised rising edge instead of the level.
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter bit EDGE_DETECT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_ff;
  logic                  level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_DEPTH-2:0], din};
    end
  end

  assign level = sync_ff[SYNC_DEPTH-1];

  generate
    if (EDGE_DETECT) begin : g_edge
      logic level_prev;

      always_ff @(posedge clk) begin
        if (reset) begin
          level_prev <= 1'b0;
        end else begin
          level_prev <= level;
        end
      end

      assign q = level & ~level_prev;
    end else begin : g_level
      assign q = level;
    end
  endgenerate

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserialiser: rebuilds left/right words from sclk/lrclk/sdata sampled in
// the clk domain and presents them as coherent pairs with a one-cycle strobe.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned AUDIO_DW = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                frame_err,
  output logic                locked
);

  localparam int unsigned WD_W = 12;

  generate
    if (AUDIO_DW < AUDIO_DW_MIN || AUDIO_DW > AUDIO_DW_MAX) begin : g_bad_dw
      $error("i2s_receiver: AUDIO_DW out of range");
    end
    if (TIMEOUT < 16 || TIMEOUT > 4095) begin : g_bad_timeout
      $error("i2s_receiver: TIMEOUT out of range");
    end
  endgenerate

  logic                sclk_rise, lrclk_s, sdata_s;
  i2s_state_t          state, state_next;
  logic [AUDIO_DW-2:0] sr;
  logic [AUDIO_DW-1:0] word, l_hold;
  logic [5:0]          cnt;
  logic [WD_W-1:0]     wd;
  logic                lrclk_prev, l_ok, l_ok_next;
  logic                transition, well_formed, timeout;
  logic                load_left, emit_pair, word_err;

  i2s_sync_edge #(.EDGE_DETECT(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk), .q(sclk_rise)
  );
  i2s_sync_edge #(.EDGE_DETECT(1'b0)) u_sync_lrclk (
    .clk(clk), .reset(reset), .din(lrclk), .q(lrclk_s)
  );
  i2s_sync_edge #(.EDGE_DETECT(1'b0)) u_sync_sdata (
    .clk(clk), .reset(reset), .din(sdata), .q(sdata_s)
  );

  // One-bit-delay framing: the bit sampled on a transition rise is the LSB of
  // the word that just ended, so the completed word includes it.
  assign word        = {sr, sdata_s};
  assign transition  = sclk_rise && (lrclk_s != lrclk_prev);
  assign well_formed = (cnt == 6'(AUDIO_DW - 1));
  assign timeout     = !sclk_rise && (wd == WD_W'(TIMEOUT - 1));
  assign locked      = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    l_ok_next  = l_ok;
    load_left  = 1'b0;
    emit_pair  = 1'b0;
    word_err   = 1'b0;
    case (state)
      SYNC: begin
        l_ok_next = 1'b0;
        if (transition) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (timeout) begin
          state_next = SYNC;
          l_ok_next  = 1'b0;
        end else if (transition) begin
          if (!well_formed) begin
            word_err  = 1'b1;
            l_ok_next = 1'b0;
          end else if (!lrclk_prev) begin
            load_left = 1'b1;
            l_ok_next = 1'b1;
          end else if (l_ok) begin
            emit_pair = 1'b1;
            l_ok_next = 1'b0;
          end
        end
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr           <= '0;
      cnt          <= '0;
      wd           <= '0;
      lrclk_prev   <= 1'b0;
      l_ok         <= 1'b0;
      l_hold       <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      l_ok         <= l_ok_next;
      sample_valid <= emit_pair;
      frame_err    <= word_err;
      if (sclk_rise) begin
        sr         <= word[AUDIO_DW-2:0];
        lrclk_prev <= lrclk_s;
        wd         <= '0;
        if (transition) begin
          cnt <= '0;
        end else if (cnt != 6'd63) begin
          cnt <= cnt + 1'b1;
        end
      end else if (wd != WD_W'(TIMEOUT - 1)) begin
        wd <= wd + 1'b1;
      end
      if (load_left) begin
        l_hold <= word;
      end
      if (emit_pair) begin
        left_chan  <= l_hold;
        right_chan <= word;
      end
    end
  end

endmodule
